// File: rtl/tnoc_output_switch_vc.sv
// Virtual-channel output switch for one router output port.
// Picks one flit per cycle across ENTRIES inputs and CHANNELS VCs.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   i_valid/o_ready   per entry/VC request and grant, bit e*CHANNELS+c
//   i_head/i_tail     per-entry flit flags
//   i_data            per-entry payload
//   o_valid           registered one-hot VC of the output flit
//   o_head/o_tail     registered flags
//   o_data            registered payload
//   i_credit_return   per-VC downstream credit pulse
//   o_vc_locked       per-VC packet lock
//   o_output_free     a flit is accepted this cycle
module tnoc_output_switch_vc #(
  parameter int ENTRIES    = 5,
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 64,
  parameter int CREDITS    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ENTRIES*CHANNELS-1:0]    i_valid,
  output logic [ENTRIES*CHANNELS-1:0]    o_ready,
  input  logic [ENTRIES-1:0]             i_head,
  input  logic [ENTRIES-1:0]             i_tail,
  input  logic [ENTRIES*DATA_WIDTH-1:0]  i_data,
  output logic [CHANNELS-1:0]            o_valid,
  output logic                           o_head,
  output logic                           o_tail,
  output logic [DATA_WIDTH-1:0]          o_data,
  input  logic [CHANNELS-1:0]            i_credit_return,
  output logic [CHANNELS-1:0]            o_vc_locked,
  output logic                           o_output_free
);

  localparam int EW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int VW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW = $clog2(CREDITS + 1);

  logic [CHANNELS-1:0] lock;
  logic [EW-1:0]       owner  [CHANNELS];
  logic [EW-1:0]       eptr   [CHANNELS];
  logic [CW-1:0]       credit [CHANNELS];
  logic [VW-1:0]       vptr;

  logic [ENTRIES-1:0]  elig [CHANNELS];
  logic [EW-1:0]       pick [CHANNELS];
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] cand;

  logic                  grant;
  logic [VW-1:0]         gvc;
  logic [CHANNELS-1:0]   gvc_oh;
  logic [EW-1:0]         gent;
  logic                  g_head;
  logic                  g_tail;
  logic [DATA_WIDTH-1:0] g_data;

  // A locked VC only admits its owner; an unlocked one only admits heads.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      for (int e = 0; e < ENTRIES; e++) begin
        elig[c][e] = i_valid[e*CHANNELS+c] &&
          (lock[c] ? (owner[c] == EW'(e)) : i_head[e]);
      end
    end
  end

  // Round-robin from eptr: first pass at/after the pointer, then wrap.
  always_comb begin
    hit  = '0;
    cand = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pick[c] = '0;
      for (int e = 0; e < ENTRIES; e++) begin
        if (!hit[c] && elig[c][e] && EW'(e) >= eptr[c]) begin
          hit[c]  = 1'b1;
          pick[c] = EW'(e);
        end
      end
      for (int e = 0; e < ENTRIES; e++) begin
        if (!hit[c] && elig[c][e]) begin
          hit[c]  = 1'b1;
          pick[c] = EW'(e);
        end
      end
      cand[c] = hit[c] && (credit[c] != '0);
    end
  end

  always_comb begin
    grant = 1'b0;
    gvc   = '0;
    for (int v = 0; v < CHANNELS; v++) begin
      if (!grant && cand[v] && VW'(v) >= vptr) begin
        grant = 1'b1;
        gvc   = VW'(v);
      end
    end
    for (int v = 0; v < CHANNELS; v++) begin
      if (!grant && cand[v]) begin
        grant = 1'b1;
        gvc   = VW'(v);
      end
    end
    gent = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      gvc_oh[c] = grant && (gvc == VW'(c));
      if (gvc == VW'(c)) gent = pick[c];
    end
    g_head = 1'b0;
    g_tail = 1'b0;
    g_data = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      if (gent == EW'(e)) begin
        g_head = i_head[e];
        g_tail = i_tail[e];
        g_data = i_data[e*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int e = 0; e < ENTRIES; e++) begin
      for (int c = 0; c < CHANNELS; c++) begin
        o_ready[e*CHANNELS+c] = gvc_oh[c] && (gent == EW'(e));
      end
    end
  end

  assign o_output_free = grant;
  assign o_vc_locked   = lock;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= '0;
      o_head  <= 1'b0;
      o_tail  <= 1'b0;
      o_data  <= '0;
      lock    <= '0;
      vptr    <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        owner[c]  <= '0;
        eptr[c]   <= '0;
        credit[c] <= CW'(CREDITS);
      end
    end else begin
      o_valid <= gvc_oh;
      if (grant) begin
        o_head <= g_head;
        o_tail <= g_tail;
        o_data <= g_data;
        vptr   <= (gvc == VW'(CHANNELS-1)) ? '0 : gvc + VW'(1);
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (gvc_oh[c]) begin
          if (g_tail) begin
            lock[c] <= 1'b0;
            eptr[c] <= (gent == EW'(ENTRIES-1)) ? '0 : gent + EW'(1);
          end else if (g_head) begin
            lock[c]  <= 1'b1;
            owner[c] <= gent;
          end
        end
        // Send and return together cancel; a surplus return saturates.
        if (gvc_oh[c] && !i_credit_return[c]) begin
          credit[c] <= credit[c] - CW'(1);
        end else if (!gvc_oh[c] && i_credit_return[c] &&
                     credit[c] != CW'(CREDITS)) begin
          credit[c] <= credit[c] + CW'(1);
        end
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chk
    a_credit_overflow: assert property (@(posedge clk) disable iff (rst)
      !(i_credit_return[c] && !gvc_oh[c] && credit[c] == CW'(CREDITS)));
    for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
      a_body_unlocked: assert property (@(posedge clk) disable iff (rst)
        !(i_valid[e*CHANNELS+c] && !lock[c] && !i_head[e]));
    end
  end

endmodule
